// File: rtl/serial_modn_if.sv
// Handshake bundle between a serial receiver (master) and the mod-N checker (slave).
interface serial_modn_if #(
    parameter int MOD   = 3,
    parameter int CNT_W = 16
);
    localparam int RW = $clog2(MOD);

    logic             start;
    logic             finish;
    logic             in_valid;
    logic             in;
    logic             lsb_first;
    logic             busy;
    logic [RW-1:0]    rem;
    logic             divisible;
    logic             rem_valid;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, finish, in_valid, in, lsb_first,
        input  busy, rem, divisible, rem_valid, bit_cnt
    );

    modport slave (
        input  start, finish, in_valid, in, lsb_first,
        output busy, rem, divisible, rem_valid, bit_cnt
    );
endinterface

// File: rtl/serial_modn.sv
// Serial divisibility checker: remainder of a framed bit stream modulo MOD,
// MSB-first or LSB-first per frame, with saturating bit counter.
module serial_modn #(
    parameter int MOD   = 3,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    serial_modn_if.slave bus
);
    localparam int                RW      = $clog2(MOD);
    localparam logic [RW:0]       MOD_W   = (RW+1)'(MOD);
    localparam logic [RW-1:0]     W_ONE   = RW'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_reg, state_next;
    logic [RW-1:0]    acc_reg, acc_next;
    logic [RW-1:0]    w_reg, w_next;
    logic [RW-1:0]    rem_reg, rem_next;
    logic             mode_reg, mode_next;
    logic             busy_reg, busy_next;
    logic             div_reg, div_next;
    logic             rv_reg, rv_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [RW-1:0]    acc_step;
    logic [RW-1:0]    w_step;
    logic [CNT_W-1:0] cnt_step;

    // Inputs are always below 2*MOD, so one conditional subtract suffices.
    function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
        logic [RW:0] d;
        d = (x >= MOD_W) ? (x - MOD_W) : x;
        return d[RW-1:0];
    endfunction

    // Candidate state after accepting the current bit (used only when ACTIVE).
    always_comb begin
        acc_step = acc_reg;
        w_step   = w_reg;
        cnt_step = cnt_reg;
        if (bus.in_valid) begin
            if (mode_reg) begin
                acc_step = reduce({1'b0, acc_reg} + {1'b0, w_reg & {RW{bus.in}}});
                w_step   = reduce({w_reg, 1'b0});
            end else begin
                acc_step = reduce({acc_reg, bus.in});
            end
            if (cnt_reg != CNT_MAX) begin
                cnt_step = cnt_reg + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        w_next     = w_reg;
        rem_next   = rem_reg;
        mode_next  = mode_reg;
        busy_next  = busy_reg;
        div_next   = div_reg;
        rv_next    = 1'b0;
        cnt_next   = cnt_reg;

        // start wins over everything, including a frame in progress.
        if (bus.start) begin
            state_next = ACTIVE;
            acc_next   = '0;
            w_next     = W_ONE;
            cnt_next   = '0;
            mode_next  = bus.lsb_first;
            busy_next  = 1'b1;
            div_next   = 1'b0;
        end else if (state_reg == ACTIVE) begin
            acc_next = acc_step;
            w_next   = w_step;
            cnt_next = cnt_step;
            if (bus.finish) begin
                state_next = IDLE;
                rem_next   = acc_step;
                div_next   = (acc_step == '0);
                rv_next    = 1'b1;
                busy_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            w_reg     <= W_ONE;
            rem_reg   <= '0;
            mode_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            div_reg   <= 1'b0;
            rv_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            w_reg     <= w_next;
            rem_reg   <= rem_next;
            mode_reg  <= mode_next;
            busy_reg  <= busy_next;
            div_reg   <= div_next;
            rv_reg    <= rv_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.rem       = rem_reg;
    assign bus.divisible = div_reg;
    assign bus.rem_valid = rv_reg;
    assign bus.bit_cnt   = cnt_reg;
endmodule

// File: tb/tb_serial_modn.sv
// Directed bench: four checkers (MOD 3/5/7, and MOD 3 with a 4-bit counter) share one stimulus.
module tb_serial_modn;
    logic clk;
    logic rst;
    logic start, finish, in_valid, din, lsb_first;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_modn_if #(.MOD(3), .CNT_W(16)) if3 ();
    serial_modn_if #(.MOD(5), .CNT_W(16)) if5 ();
    serial_modn_if #(.MOD(7), .CNT_W(16)) if7 ();
    serial_modn_if #(.MOD(3), .CNT_W(4))  ifc ();

    assign if3.start = start;  assign if3.finish = finish;  assign if3.in_valid = in_valid;
    assign if3.in = din;       assign if3.lsb_first = lsb_first;
    assign if5.start = start;  assign if5.finish = finish;  assign if5.in_valid = in_valid;
    assign if5.in = din;       assign if5.lsb_first = lsb_first;
    assign if7.start = start;  assign if7.finish = finish;  assign if7.in_valid = in_valid;
    assign if7.in = din;       assign if7.lsb_first = lsb_first;
    assign ifc.start = start;  assign ifc.finish = finish;  assign ifc.in_valid = in_valid;
    assign ifc.in = din;       assign ifc.lsb_first = lsb_first;

    serial_modn #(.MOD(3), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    serial_modn #(.MOD(5), .CNT_W(16)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
    serial_modn #(.MOD(7), .CNT_W(16)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));
    serial_modn #(.MOD(3), .CNT_W(4))  dutc (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input logic lsb);
        start = 1'b1; lsb_first = lsb;
        tick;
        start = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic fin);
        in_valid = 1'b1; din = b; finish = fin;
        tick;
        in_valid = 1'b0; din = 1'b0; finish = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; finish = 0; in_valid = 0; din = 0; lsb_first = 0;
        tick; tick;
        check_eq("rst_busy", 32'(if3.busy), 0);
        check_eq("rst_rem", 32'(if3.rem), 0);
        check_eq("rst_div", 32'(if3.divisible), 0);
        check_eq("rst_rv", 32'(if3.rem_valid), 0);
        check_eq("rst_cnt", 32'(if3.bit_cnt), 0);
        rst = 1'b0;
        tick;

        // Modulus 3, MSB-first 1,1,0 = 6
        open_frame(1'b0);
        check_eq("t1_busy", 32'(if3.busy), 1);
        check_eq("t1_cnt0", 32'(if3.bit_cnt), 0);
        bit_in(1, 0); bit_in(1, 0);
        check_eq("t1_rv_early", 32'(if3.rem_valid), 0);
        bit_in(0, 1);
        check_eq("t1_rem", 32'(if3.rem), 0);
        check_eq("t1_div", 32'(if3.divisible), 1);
        check_eq("t1_rv", 32'(if3.rem_valid), 1);
        check_eq("t1_cnt", 32'(if3.bit_cnt), 3);
        check_eq("t1_busy_end", 32'(if3.busy), 0);
        tick;
        check_eq("t1_rv_drop", 32'(if3.rem_valid), 0);
        check_eq("t1_rem_hold", 32'(if3.rem), 0);
        $display("frame t1 mod3 msb 110: rem=%0d div=%0d cnt=%0d", if3.rem, if3.divisible, if3.bit_cnt);

        // Modulus 5, LSB-first 1,1,0,1 = 11, stall mid-frame; lsb_first changes after start
        open_frame(1'b1);
        lsb_first = 1'b0;
        bit_in(1, 0); bit_in(1, 0);
        tick; tick;
        check_eq("t2_stall_cnt", 32'(if5.bit_cnt), 2);
        bit_in(0, 0); bit_in(1, 1);
        check_eq("t2_rem", 32'(if5.rem), 1);
        check_eq("t2_div", 32'(if5.divisible), 0);
        check_eq("t2_cnt", 32'(if5.bit_cnt), 4);
        check_eq("t2_rv", 32'(if5.rem_valid), 1);
        $display("frame t2 mod5 lsb 1101: rem=%0d div=%0d cnt=%0d", if5.rem, if5.divisible, if5.bit_cnt);
        tick;

        // Modulus 7, MSB-first 0xFF = 255 -> 3, then back-to-back restart with 1110 = 14 -> 0
        open_frame(1'b0);
        for (int i = 0; i < 8; i++) bit_in(1, i == 7);
        check_eq("t3_rem_ff", 32'(if7.rem), 3);
        check_eq("t3_div_ff", 32'(if7.divisible), 0);
        check_eq("t3_rv_ff", 32'(if7.rem_valid), 1);
        open_frame(1'b0);
        check_eq("t3_rv_end", 32'(if7.rem_valid), 0);
        check_eq("t3_rem_keep", 32'(if7.rem), 3);
        check_eq("t3_busy", 32'(if7.busy), 1);
        check_eq("t3_div_clr", 32'(if7.divisible), 0);
        bit_in(1, 0); bit_in(1, 0); bit_in(1, 0); bit_in(0, 1);
        check_eq("t3_rem_14", 32'(if7.rem), 0);
        check_eq("t3_div_14", 32'(if7.divisible), 1);
        check_eq("t3_cnt_14", 32'(if7.bit_cnt), 4);
        $display("frame t3 mod7 msb 1110: rem=%0d div=%0d cnt=%0d", if7.rem, if7.divisible, if7.bit_cnt);
        tick;

        // Modulus 3 abort: start together with a valid bit and finish
        open_frame(1'b0);
        bit_in(1, 0);
        start = 1'b1; in_valid = 1'b1; din = 1'b1; finish = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b0; din = 1'b0; finish = 1'b0;
        check_eq("t4_rv_abort", 32'(if3.rem_valid), 0);
        check_eq("t4_busy", 32'(if3.busy), 1);
        check_eq("t4_cnt0", 32'(if3.bit_cnt), 0);
        check_eq("t4_rem_keep", 32'(if3.rem), 2);
        bit_in(1, 0); bit_in(0, 1);
        check_eq("t4_rem", 32'(if3.rem), 2);
        check_eq("t4_rv", 32'(if3.rem_valid), 1);
        check_eq("t4_cnt", 32'(if3.bit_cnt), 2);
        $display("frame t4 mod3 msb 10 after abort: rem=%0d cnt=%0d", if3.rem, if3.bit_cnt);
        tick;

        // Asynchronous reset between edges, then a stray finish
        open_frame(1'b0);
        bit_in(1, 0); bit_in(1, 0);
        #3 rst = 1'b1;
        #1;
        check_eq("t5_busy", 32'(if3.busy), 0);
        check_eq("t5_cnt", 32'(if3.bit_cnt), 0);
        check_eq("t5_rem", 32'(if3.rem), 0);
        check_eq("t5_div", 32'(if3.divisible), 0);
        #1 rst = 1'b0;
        bit_in(1, 1);
        check_eq("t5_rv_stray", 32'(if3.rem_valid), 0);
        check_eq("t5_busy_stray", 32'(if3.busy), 0);
        check_eq("t5_cnt_stray", 32'(if3.bit_cnt), 0);
        $display("frame t5 reset mid-frame: busy=%0d rem=%0d", if3.busy, if3.rem);

        // 20 ones into the 4-bit counter instance, then an empty frame
        open_frame(1'b0);
        for (int i = 0; i < 20; i++) begin
            bit_in(1, i == 19);
            if (i == 14) check_eq("t6_cnt_15", 32'(ifc.bit_cnt), 15);
        end
        check_eq("t6_cnt_sat", 32'(ifc.bit_cnt), 15);
        check_eq("t6_rem", 32'(ifc.rem), 0);
        check_eq("t6_div", 32'(ifc.divisible), 1);
        check_eq("t6_cnt_wide", 32'(if3.bit_cnt), 20);
        check_eq("t6_rem7", 32'(if7.rem), 3);
        $display("frame t6 20 ones cnt4: rem=%0d cnt=%0d", ifc.rem, ifc.bit_cnt);
        tick;
        open_frame(1'b0);
        finish = 1'b1;
        tick;
        finish = 1'b0;
        check_eq("t7_rem", 32'(ifc.rem), 0);
        check_eq("t7_div", 32'(ifc.divisible), 1);
        check_eq("t7_cnt", 32'(ifc.bit_cnt), 0);
        check_eq("t7_rv", 32'(ifc.rem_valid), 1);
        check_eq("t7_rem7", 32'(if7.rem), 0);
        check_eq("t7_div7", 32'(if7.divisible), 1);
        $display("frame t7 empty: rem=%0d div=%0d cnt=%0d", if7.rem, if7.divisible, if7.bit_cnt);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
